// File: rtl/mult_accumulate_stage.sv
// Handshaked accumulator that sums COUNT multiplier products per result.
// Optional macro MULT_ACC_SATURATE_EN selects saturating instead of wrapping accumulation.
module mult_accumulate_stage #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int COUNT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               ready_q;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   next_acc;
    logic               carry;
    logic               accept;

    // Gating with rst keeps the stage from advertising ready while held in reset.
    assign prod_ready = ready_q & ~rst;
    assign accept     = prod_valid & prod_ready;

    always_comb begin
        sum   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry = sum[ACC_W];
`ifdef MULT_ACC_SATURATE_EN
        // Once saturated, any further add carries again (or adds zero), so it stays pinned.
        next_acc = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        next_acc = sum[ACC_W-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ready_q   <= 1'b1;
            acc_valid <= 1'b0;
            acc_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc      <= next_acc;
                        overflow <= overflow | carry;
                        if (count == LAST_CNT) begin
                            acc_out   <= next_acc;
                            count     <= '0;
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                            ready_q   <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        acc       <= '0;
                        overflow  <= 1'b0;
                        state     <= ACCUM;
                        acc_valid <= 1'b0;
                        ready_q   <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accumulate_stage.sv
// Directed self-checking bench: default instance plus a COUNT=2, ACC_W=16 instance for overflow.
module tb_mult_accumulate_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [15:0] prod = '0;
    logic        acc_valid;
    logic        acc_ready = 1'b1;
    logic [23:0] acc_out;
    logic        overflow;

    logic        s_prod_valid = 1'b0;
    logic        s_prod_ready;
    logic [15:0] s_prod = '0;
    logic        s_acc_valid;
    logic        s_acc_ready = 1'b1;
    logic [15:0] s_acc_out;
    logic        s_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_accumulate_stage #(.PROD_W(16), .ACC_W(24), .COUNT(8)) dut (
        .clk(clk), .rst(rst),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_out(acc_out), .overflow(overflow)
    );

    mult_accumulate_stage #(.PROD_W(16), .ACC_W(16), .COUNT(2)) dut_small (
        .clk(clk), .rst(rst),
        .prod_valid(s_prod_valid), .prod_ready(s_prod_ready), .prod(s_prod),
        .acc_valid(s_acc_valid), .acc_ready(s_acc_ready),
        .acc_out(s_acc_out), .overflow(s_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present v until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [15:0] v);
        bit done = 0;
        prod       = v;
        prod_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (prod_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 0, 1);
        prod_valid = 1'b0;
    endtask

    task automatic send_s(input logic [15:0] v);
        bit done = 0;
        s_prod       = v;
        s_prod_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (s_prod_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("send_s_timeout", 0, 1);
        s_prod_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc_valid", acc_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_prod_ready", prod_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_prod_ready", prod_ready, 1);

        // Products 1..8 back-to-back
        for (int i = 1; i <= 8; i++) begin
            check("b2b_ready", prod_ready, 1);
            send(16'(i));
        end
        check("b2b_valid", acc_valid, 1);
        check("b2b_sum", acc_out, 36);
        check("b2b_ovf", overflow, 0);
        check("b2b_ready_hold", prod_ready, 0);
        idle_cycle();
        check("b2b_ready_after", prod_ready, 1);
        check("b2b_valid_after", acc_valid, 0);

        // Maximum products
        for (int i = 0; i < 8; i++) send(16'd65025);
        check("max_sum", acc_out, 520200);
        check("max_ovf", overflow, 0);
        check("max_valid", acc_valid, 1);
        idle_cycle();

        // Backpressure with upstream holding the next group's first product
        acc_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd10);
        prod       = 16'd7;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", acc_valid, 1);
            check("bp_sum", acc_out, 80);
            check("bp_ready", prod_ready, 0);
            idle_cycle();
        end
        acc_ready = 1'b1;
        send(16'd7);
        for (int i = 1; i <= 7; i++) send(16'(i));
        check("bp_next_valid", acc_valid, 1);
        check("bp_next_sum", acc_out, 35);
        idle_cycle();

        // Bubbles: valid 1,0,0 pattern with products of 3
        for (int i = 0; i < 8; i++) begin
            send(16'd3);
            if (i < 7) begin
                check("bub_no_valid", acc_valid, 0);
                idle_cycle();
                idle_cycle();
            end
        end
        check("bub_valid", acc_valid, 1);
        check("bub_sum", acc_out, 24);
        idle_cycle();

        // Small instance: overflow with wrap or saturation
        send_s(16'd65025);
        check("s_mid_valid", s_acc_valid, 0);
        send_s(16'd65025);
        check("s_valid", s_acc_valid, 1);
`ifdef MULT_ACC_SATURATE_EN
        check("s_sum", s_acc_out, 65535);
`else
        check("s_sum", s_acc_out, 64514);
`endif
        check("s_ovf", s_overflow, 1);
        idle_cycle();
        check("s_ovf_clear", s_overflow, 0);
        send_s(16'd1);
        send_s(16'd2);
        check("s_sum2", s_acc_out, 3);
        check("s_ovf2", s_overflow, 0);
        idle_cycle();

        // Reset mid-HOLD
        acc_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd2);
        check("hold_sum", acc_out, 16);
        #2 rst = 1'b1;
        #1;
        check("hrst_acc_valid", acc_valid, 0);
        check("hrst_acc_out", acc_out, 0);
        check("hrst_overflow", overflow, 0);
        check("hrst_prod_ready", prod_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("hrst_ready_after", prod_ready, 1);
        acc_ready = 1'b1;

        // Reset mid-group discards the partial sum
        for (int i = 0; i < 3; i++) send(16'd100);
        #2 rst = 1'b1;
        #1;
        check("grst_prod_ready", prod_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) send(16'd1);
        check("grst_sum", acc_out, 8);
        check("grst_valid", acc_valid, 1);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_accumulate_stage.md
Name: mult_accumulate_stage

Overview:
- Downstream consumer of the 8x8 combinational multiplier's 16-bit product.
- Accepts one product per cycle over a valid/ready handshake and sums COUNT consecutive products into an accumulator, i.e. one dot-product term group.
- Presents the finished sum on a valid/ready output, then clears and starts the next group.
- Gives the multiplier examples a sequential, handshaked neighbour for equivalence and property checking.

Parameters:
- PROD_W, 16, width of incoming product.
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- COUNT, 8, number of products summed per result; must be >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- prod_valid, input, 1, upstream product valid.
- prod_ready, output, 1, stage can accept a product this cycle.
- prod, input, PROD_W, unsigned product from the multiplier.
- acc_valid, output, 1, result valid.
- acc_ready, input, 1, downstream accepts result.
- acc_out, output, ACC_W, unsigned accumulated sum.
- overflow, output, 1, sum of the current group exceeded 2^ACC_W-1.

Behaviour:
- Reset (async assert, sync release): state=ACCUM, acc=0, count=0, acc_valid=0, acc_out=0, overflow=0, prod_ready=1 after reset deasserts.
- States:
  - ACCUM: prod_ready=1, acc_valid=0.
  - HOLD: prod_ready=0, acc_valid=1.
- Accept: a product is accepted when prod_valid && prod_ready.
  - prod is zero-extended to ACC_W+1 bits and added to acc.
  - A carry out of bit ACC_W-1 sets overflow. overflow is sticky for the group.
- ACCUM, accept with count < COUNT-1: acc <= acc+prod (per overflow policy), count <= count+1, stay in ACCUM.
- ACCUM, accept with count == COUNT-1: acc_out <= final sum, overflow updated, count <= 0, go to HOLD.
  - acc_valid rises the cycle after the last product is accepted (latency 1).
- ACCUM, no accept: all state holds.
- HOLD: acc_out and overflow stay stable while acc_valid && !acc_ready.
- HOLD, acc_ready=1: result is consumed. Next cycle: acc=0, overflow=0, state=ACCUM, prod_ready=1.
  - No product is accepted in the consume cycle; maximum throughput is one result per COUNT+1 cycles.
- prod_valid while in HOLD: ignored. Upstream must hold prod until prod_ready.
- COUNT=1: every accepted product goes straight to HOLD.
- Reset mid-group or mid-HOLD: partial sum, count and pending result are discarded; outputs return to their reset values immediately.
- Counter width: $clog2(COUNT) bits, minimum 1.

Optional Feature:
- Macro: MULT_ACC_SATURATE_EN.
- Defined: on carry-out, acc saturates to all-ones (2^ACC_W-1) and stays there for the rest of the group. overflow=1.
- Undefined: acc wraps modulo 2^ACC_W. overflow still flags that a carry occurred during the group.
- Handshake, latency and state machine are identical in both builds.

Test Plan:
- Reset: assert rst mid-operation -> acc_valid=0, acc_out=0, overflow=0, prod_ready=0 during rst, then prod_ready=1 after deassert.
- Defaults, products 1..8 back-to-back, acc_ready=1 -> acc_valid one cycle after 8th accept, acc_out=36, overflow=0, prod_ready=1 two cycles after the last accept.
- Defaults, eight products of 65025 -> acc_out=520200, overflow=0.
- Backpressure: acc_ready=0 for 5 cycles after result, prod_valid=1 throughout -> acc_out stable, prod_ready=0, no product lost; next group sums correctly once acc_ready=1.
- COUNT=2, ACC_W=16, products 65025 and 65025:
  - Without macro -> acc_out=64514, overflow=1.
  - With MULT_ACC_SATURATE_EN -> acc_out=65535, overflow=1.
- Bubbles: prod_valid toggled 1,0,0,1,... with products of 3 -> result only after 8 accepts, acc_out=24.
